// File: rtl/vga_reg_ctrl.sv
// vga_reg_ctrl: frame tick, debounced buttons, displayed register value
// and zoom ping-pong for the vgaREG overlay, all in the px_clk domain.

module vga_reg_ctrl_debounce #(
    parameter int FRAMES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic press
);

    localparam logic [2:0] RUN_LAST = 3'(FRAMES - 1);

    logic       sync1;
    logic       sync2;
    logic       state;
    logic [2:0] run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // run counts consecutive samples that disagree with the settled state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= 1'b0;
            run   <= 3'd0;
        end else if (tick) begin
            if (sync2 == state) begin
                run <= 3'd0;
            end else if (run == RUN_LAST) begin
                state <= sync2;
                run   <= 3'd0;
            end else begin
                run <= run + 3'd1;
            end
        end
    end

    assign press = tick && sync2 && !state && (run == RUN_LAST);

endmodule

module vga_reg_ctrl #(
    parameter int          FRAMES_PER_STEP = 16,
    parameter int          FRAMES_PER_ZOOM = 128,
    parameter int          ZOOM_MAX        = 4,
    parameter logic [15:0] REG_INIT        = 16'h0019,
    parameter int          DEBOUNCE_FRAMES = 3,
    parameter int          IDLE_FRAMES     = 255
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic        endframe,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [15:0] register,
    output logic [2:0]  zoom,
    output logic        frame_tick,
    output logic        mode_manual,
    output logic        led
);

    localparam logic       MODE_AUTO   = 1'b0;
    localparam logic       MODE_MANUAL = 1'b1;
    localparam logic       ZS_GROW     = 1'b0;
    localparam logic       ZS_SHRINK   = 1'b1;

    localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] ZOOM_LAST = 8'(FRAMES_PER_ZOOM - 1);
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_FRAMES - 1);
    localparam logic [2:0] ZMAX      = 3'(ZOOM_MAX);

    logic        ef_s1;
    logic        ef_s2;
    logic        ef_s3;
    logic        up_press;
    logic        down_press;
    logic        any_press;
    logic        mode;
    logic        zstate;
    logic [7:0]  step_cnt;
    logic [7:0]  idle_cnt;
    logic [7:0]  zoom_cnt;
    logic [15:0] stepped;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            ef_s1      <= 1'b0;
            ef_s2      <= 1'b0;
            ef_s3      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            ef_s1      <= endframe;
            ef_s2      <= ef_s1;
            ef_s3      <= ef_s2;
            frame_tick <= ef_s2 & ~ef_s3;
        end
    end

    vga_reg_ctrl_debounce #(
        .FRAMES (DEBOUNCE_FRAMES)
    ) u_db_up (
        .clk   (px_clk),
        .rst_n (rst_n),
        .tick  (frame_tick),
        .raw   (btn_up),
        .press (up_press)
    );

    vga_reg_ctrl_debounce #(
        .FRAMES (DEBOUNCE_FRAMES)
    ) u_db_down (
        .clk   (px_clk),
        .rst_n (rst_n),
        .tick  (frame_tick),
        .raw   (btn_down),
        .press (down_press)
    );

    assign any_press = up_press | down_press;

    // simultaneous up and down cancel out
    always_comb begin
        stepped = register;
        if (up_press && !down_press) begin
            stepped = register + 16'd1;
        end else if (down_press && !up_press) begin
            stepped = register - 16'd1;
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            register <= REG_INIT;
            mode     <= MODE_AUTO;
            step_cnt <= 8'd0;
            idle_cnt <= 8'd0;
        end else if (frame_tick) begin
            if (mode == MODE_AUTO) begin
                if (any_press) begin
                    mode     <= MODE_MANUAL;
                    register <= stepped;
                    step_cnt <= 8'd0;
                    idle_cnt <= 8'd0;
                end else if (step_cnt == STEP_LAST) begin
                    register <= register + 16'd1;
                    step_cnt <= 8'd0;
                end else begin
                    step_cnt <= step_cnt + 8'd1;
                end
            end else begin
                if (any_press) begin
                    register <= stepped;
                    idle_cnt <= 8'd0;
                end else if (idle_cnt == IDLE_LAST) begin
                    mode     <= MODE_AUTO;
                    step_cnt <= 8'd0;
                    idle_cnt <= 8'd0;
                end else begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            zoom     <= 3'd0;
            zstate   <= ZS_GROW;
            zoom_cnt <= 8'd0;
        end else if (frame_tick) begin
            if (zoom_cnt == ZOOM_LAST) begin
                zoom_cnt <= 8'd0;
                if (zstate == ZS_GROW) begin
                    if (zoom == ZMAX) begin
                        zstate <= ZS_SHRINK;
                        zoom   <= zoom - 3'd1;
                    end else begin
                        zoom <= zoom + 3'd1;
                    end
                end else begin
                    if (zoom == 3'd0) begin
                        zstate <= ZS_GROW;
                        zoom   <= zoom + 3'd1;
                    end else begin
                        zoom <= zoom - 3'd1;
                    end
                end
            end else begin
                zoom_cnt <= zoom_cnt + 8'd1;
            end
        end
    end

    assign mode_manual = (mode == MODE_MANUAL);
    assign led         = (zstate == ZS_GROW);

endmodule

// File: tb/tb_vga_reg_ctrl.sv
// tb_vga_reg_ctrl: three parameterisations driven by common stimulus,
// compared every cycle against a frame-level behavioural model.

module tb_vga_reg_ctrl;

    localparam int ND   = 3;
    localparam int DB   = 3;
    localparam int ZMAX = 4;

    logic px_clk = 1'b0;
    logic rst_n = 1'b0;
    logic endframe = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;

    logic [15:0] reg_o  [ND];
    logic [2:0]  zoom_o [ND];
    logic        tick_o [ND];
    logic        man_o  [ND];
    logic        led_o  [ND];

    int p_fps [ND] = '{16, 16, 255};
    int p_fpz [ND] = '{128, 1, 128};
    int p_idle[ND] = '{255, 255, 20};
    logic [15:0] p_init[ND] = '{16'h0019, 16'hFFFF, 16'h0000};

    int errors = 0;
    int checks = 0;

    always #5 px_clk = ~px_clk;

    vga_reg_ctrl u_d0 (
        .px_clk(px_clk), .rst_n(rst_n), .endframe(endframe),
        .btn_up(btn_up), .btn_down(btn_down),
        .register(reg_o[0]), .zoom(zoom_o[0]), .frame_tick(tick_o[0]),
        .mode_manual(man_o[0]), .led(led_o[0])
    );

    vga_reg_ctrl #(
        .REG_INIT(16'hFFFF), .FRAMES_PER_ZOOM(1)
    ) u_d1 (
        .px_clk(px_clk), .rst_n(rst_n), .endframe(endframe),
        .btn_up(btn_up), .btn_down(btn_down),
        .register(reg_o[1]), .zoom(zoom_o[1]), .frame_tick(tick_o[1]),
        .mode_manual(man_o[1]), .led(led_o[1])
    );

    vga_reg_ctrl #(
        .REG_INIT(16'h0000), .FRAMES_PER_STEP(255), .IDLE_FRAMES(20)
    ) u_d2 (
        .px_clk(px_clk), .rst_n(rst_n), .endframe(endframe),
        .btn_up(btn_up), .btn_down(btn_down),
        .register(reg_o[2]), .zoom(zoom_o[2]), .frame_tick(tick_o[2]),
        .mode_manual(man_o[2]), .led(led_o[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model: frame-level rules ----
    bit          h[4];
    bit          m_tick;
    int          m_ticks;
    bit          bq[2][$];
    bit          bst[2];
    bit          ev[2];
    bit          all_eq;
    bit          smp;
    logic [15:0] m_reg[ND];
    bit          m_man[ND];
    int          m_idle[ND];
    int          m_auto[ND];

    always @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) h[i] = 1'b0;
            m_tick  = 1'b0;
            m_ticks = 0;
            for (int b = 0; b < 2; b++) begin
                bq[b].delete();
                bst[b] = 1'b0;
            end
            for (int d = 0; d < ND; d++) begin
                m_reg[d]  = p_init[d];
                m_man[d]  = 1'b0;
                m_idle[d] = 0;
                m_auto[d] = 0;
            end
        end else begin
            if (m_tick) begin
                m_ticks++;
                for (int b = 0; b < 2; b++) begin
                    smp = (b == 0) ? btn_up : btn_down;
                    bq[b].push_back(smp);
                    if (bq[b].size() > DB) void'(bq[b].pop_front());
                    ev[b] = 1'b0;
                    if (bq[b].size() == DB) begin
                        all_eq = 1'b1;
                        foreach (bq[b][i]) if (bq[b][i] != bq[b][0]) all_eq = 1'b0;
                        if (all_eq && bq[b][0] != bst[b]) begin
                            bst[b] = bq[b][0];
                            ev[b]  = bst[b];
                        end
                    end
                end
                for (int d = 0; d < ND; d++) begin
                    if (ev[0] || ev[1]) begin
                        m_reg[d]  = m_reg[d] + 16'(ev[0]) - 16'(ev[1]);
                        if (!m_man[d]) m_auto[d] = 0;
                        m_man[d]  = 1'b1;
                        m_idle[d] = 0;
                    end else if (!m_man[d]) begin
                        m_auto[d]++;
                        if (m_auto[d] == p_fps[d]) begin
                            m_reg[d]  = m_reg[d] + 16'd1;
                            m_auto[d] = 0;
                        end
                    end else begin
                        m_idle[d]++;
                        if (m_idle[d] == p_idle[d]) begin
                            m_man[d]  = 1'b0;
                            m_idle[d] = 0;
                            m_auto[d] = 0;
                        end
                    end
                end
            end
            h[3] = h[2];
            h[2] = h[1];
            h[1] = h[0];
            h[0] = endframe;
            m_tick = h[2] && !h[3];
        end
    end

    // zoom as a triangle wave of the number of completed zoom steps
    function automatic int exp_zoom(input int d);
        int n;
        int p;
        n = m_ticks / p_fpz[d];
        p = n % (2 * ZMAX);
        return (p <= ZMAX) ? p : 2 * ZMAX - p;
    endfunction

    function automatic int exp_led(input int d);
        int n;
        int p;
        n = m_ticks / p_fpz[d];
        p = n % (2 * ZMAX);
        return (n == 0 || (p >= 1 && p <= ZMAX)) ? 1 : 0;
    endfunction

    always @(negedge px_clk) begin
        if (rst_n) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("d%0d.register", d), int'(reg_o[d]), int'(m_reg[d]));
                chk($sformatf("d%0d.zoom", d), int'(zoom_o[d]), exp_zoom(d));
                chk($sformatf("d%0d.frame_tick", d), int'(tick_o[d]), int'(m_tick));
                chk($sformatf("d%0d.mode_manual", d), int'(man_o[d]), int'(m_man[d]));
                chk($sformatf("d%0d.led", d), int'(led_o[d]), exp_led(d));
            end
        end
    end

    int tick_seen;
    always @(negedge px_clk or negedge rst_n) begin
        if (!rst_n) tick_seen <= 0;
        else if (tick_o[0]) tick_seen <= tick_seen + 1;
    end

    task automatic frame(input int hi);
        @(negedge px_clk);
        endframe = 1'b1;
        repeat (hi) @(negedge px_clk);
        endframe = 1'b0;
        repeat ($urandom_range(8, 14)) @(negedge px_clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame($urandom_range(1, 4));
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s d%0d.register", tag, d), int'(reg_o[d]), int'(p_init[d]));
            chk($sformatf("%s d%0d.zoom", tag, d), int'(zoom_o[d]), 0);
            chk($sformatf("%s d%0d.frame_tick", tag, d), int'(tick_o[d]), 0);
            chk($sformatf("%s d%0d.mode_manual", tag, d), int'(man_o[d]), 0);
            chk($sformatf("%s d%0d.led", tag, d), int'(led_o[d]), 1);
        end
    endtask

    int z_tab[10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    int l_tab[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};

    initial begin
        repeat (4) @(negedge px_clk);
        chk_reset_vals("hold");
        rst_n = 1'b1;
        repeat (3) @(negedge px_clk);
        chk_reset_vals("post_reset");

        frame(100);
        chk("long_level_ticks", tick_seen, 1);
        chk("ping_pong_zoom_1", int'(zoom_o[1]), z_tab[0]);
        chk("ping_pong_led_1", int'(led_o[1]), l_tab[0]);
        for (int i = 2; i <= 48; i++) begin
            frame($urandom_range(1, 4));
            if (i <= 10) begin
                chk($sformatf("ping_pong_zoom_%0d", i), int'(zoom_o[1]), z_tab[i-1]);
                chk($sformatf("ping_pong_led_%0d", i), int'(led_o[1]), l_tab[i-1]);
            end
            if (i == 16) chk("wrap_ffff_plus_1", int'(reg_o[1]), 16'h0000);
        end
        chk("auto_48_frames", int'(reg_o[0]), 16'h001C);
        chk("tick_count_48", tick_seen, 48);

        rst_n = 1'b0;
        @(negedge px_clk);
        rst_n = 1'b1;
        @(negedge px_clk);

        btn_down = 1'b1;
        frames(3);
        chk("down_wrap_0000", int'(reg_o[2]), 16'hFFFF);
        chk("down_manual", int'(man_o[2]), 1);
        chk("down_default", int'(reg_o[0]), 16'h0018);
        btn_down = 1'b0;
        frames(3);

        btn_up = 1'b1;
        frames(2);
        btn_up = 1'b0;
        frames(3);
        chk("glitch_no_step", int'(reg_o[2]), 16'hFFFF);
        chk("glitch_still_manual", int'(man_o[2]), 1);

        frames(12);
        chk("idle_return_auto", int'(man_o[2]), 0);
        chk("idle_default_stays", int'(man_o[0]), 1);

        btn_up = 1'b1;
        frames(50);
        chk("held_up_manual", int'(man_o[0]), 1);
        btn_up = 1'b0;
        frames(3);

        btn_up   = 1'b1;
        btn_down = 1'b1;
        frames(3);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        frames(3);

        frames(303);
        btn_up = 1'b1;
        frames(3);
        btn_up = 1'b0;
        chk("pre_reset_zoom3", int'(zoom_o[0]), 3);
        chk("pre_reset_manual", int'(man_o[0]), 1);

        @(posedge px_clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        #1 rst_n = 1'b1;

        frames(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
